// File: rtl/uart_rx_stream.sv
// uart_rx_stream: oversampling UART receiver, byte out via valid/ready.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around the decision point.
module uart_rx_stream #(
  parameter int    CLOCK_FREQ = 50_000_000,
  parameter int    BAUD_RATE  = 115_200,
  parameter int    OVERSAMPLE = 16,
  parameter string PARITY     = "NONE"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int SAMPLE_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_DEC   = OW'(OVERSAMPLE / 2 + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [OW-1:0] OS_V0 = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_V1 = OW'(OVERSAMPLE / 2);
`endif

  if (SAMPLE_DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0)
  begin : g_bad_cfg
    $fatal(1, "uart_rx_stream: invalid CLOCK/BAUD/OVERSAMPLE");
  end
  if (PARITY != "NONE" && PARITY != "EVEN" && PARITY != "ODD")
  begin : g_bad_par
    $fatal(1, "uart_rx_stream: PARITY must be NONE, EVEN or ODD");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [DW-1:0]   div_q, div_d;
  logic [OW-1:0]   os_q, os_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]      smp_q, smp_d;
`endif

  logic tick, dec, end_p, bit_val, exp_par;

  assign tick  = (div_q == DIV_LAST);
  assign dec   = tick && (os_q == OS_DEC);
  assign end_p = tick && (os_q == OS_LAST);
  assign exp_par = PAR_ODD ? ~^shift_q : ^shift_q;

`ifdef UART_RX_MAJORITY_EN
  assign bit_val = (smp_q[0] & smp_q[1]) |
                   (smp_q[0] & rx_s_q) |
                   (smp_q[1] & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + DW'(1);
    os_d      = os_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    smp_d = smp_q;
    if (tick && os_q == OS_V0) smp_d[0] = rx_s_q;
    if (tick && os_q == OS_V1) smp_d[1] = rx_s_q;
`endif
    if (tick) os_d = (os_q == OS_LAST) ? '0 : os_q + OW'(1);
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        os_d  = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (dec && bit_val) begin
          state_d = S_IDLE;
        end else if (end_p) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (dec) shift_d = {bit_val, shift_q[7:1]};
        if (end_p) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (dec) par_d = bit_val;
        if (end_p) state_d = S_STOP;
      end
      S_STOP: begin
        // Leave at mid-stop-bit so a following start edge is not missed.
        if (dec) begin
          if (!bit_val) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end else if (PAR_EN && (par_q != exp_par)) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_IDLE;
            if (!m_valid_q || m_ready) begin
              m_data_d  = shift_q;
              m_valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        div_d = '0;
        os_d  = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_q     <= '0;
      os_q      <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      smp_q     <= 2'b11;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      div_q     <= div_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_MAJORITY_EN
      smp_q     <= smp_d;
`endif
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: frame-level model of two receivers (no parity / even)
// checked every cycle, plus literal latency and data expectations.
`timescale 1ns/1ps
module tb_uart_rx_stream;

  localparam int CF  = 3_686_400;
  localparam int BR  = 115_200;
  localparam int OS  = 16;
  localparam int DIV = CF / (BR * OS);
  localparam int BIT = OS * DIV;

  // Edges from the RX fall to the stop decision: 2 sync + 1 idle detect,
  // nb whole bits, then OS/2+2 sample periods to reach sample OS/2+1.
  function automatic int stop_lat(int nb);
    return 3 + nb * BIT + (OS / 2 + 2) * DIV;
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rx, rdy, mv, pe, fe, ov;
  logic [7:0] md [2];

  uart_rx_stream #(
    .CLOCK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .PARITY("NONE")
  ) u_none (
    .clk(clk), .rst(rst), .RX(rx[0]),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0])
  );

  uart_rx_stream #(
    .CLOCK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .PARITY("EVEN")
  ) u_even (
    .clk(clk), .rst(rst), .RX(rx[1]),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rise_at [2];
  int pulse_at [2];
  int hs_cnt [2];

  typedef enum {E_GOOD, E_PERR, E_FERR} ev_k;
  typedef struct {
    int         lane;
    int         at;
    ev_k        k;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  logic [1:0] m_v;
  logic [7:0] m_d [2];

  task automatic check(string nm, int lane, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h",
               nm, lane, cyc, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // pmode < 0: no parity bit; otherwise the parity bit value to send.
  task automatic send(int lane, logic [7:0] d, int pmode,
                      int glitch_c, int abort_c);
    logic [10:0] bits;
    int          nb;
    ev_t         e;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pmode >= 0) bits[9] = pmode[0];
    nb   = (pmode < 0) ? 10 : 11;
    e.lane = lane;
    e.at   = cyc + stop_lat(nb - 1);
    e.k    = (pmode >= 0 && pmode[0] != ^d) ? E_PERR : E_GOOD;
    e.d    = d;
    evq.push_back(e);
    for (int c = 0; c < nb * BIT; c++) begin
      if (c == abort_c) begin
        rx[lane] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rx[lane] = bits[c / BIT] ^ (c == glitch_c);
      @(negedge clk);
    end
    rx[lane] = 1'b1;
  endtask

  task automatic send_break(int lane, int nbits);
    ev_t e;
    e.lane = lane;
    e.at   = cyc + stop_lat(9);
    e.k    = E_FERR;
    e.d    = 8'h00;
    evq.push_back(e);
    rx[lane] = 1'b0;
    idle(nbits * BIT);
    rx[lane] = 1'b1;
  endtask

  initial begin : cmp
    logic [1:0] r_rdy, r_mv, prev_mv;
    logic       r_rst, good, hv, xp, xf, xo;
    logic [7:0] gd;
    m_v = 2'b00;
    m_d[0] = 8'h00;
    m_d[1] = 8'h00;
    prev_mv = 2'b00;
    for (int l = 0; l < 2; l++) begin
      rise_at[l] = 0;
      pulse_at[l] = 0;
      hs_cnt[l] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      r_rst = rst;
      r_rdy = rdy;
      r_mv  = mv;
      #1;
      if (r_rst) evq.delete();
      for (int l = 0; l < 2; l++) begin
        good = 1'b0; xp = 1'b0; xf = 1'b0; xo = 1'b0; gd = 8'h00;
        if (r_mv[l] === 1'b1 && r_rdy[l]) hs_cnt[l]++;
        if (r_rst) begin
          m_v[l] = 1'b0;
          m_d[l] = 8'h00;
        end else begin
          for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].lane == l && evq[i].at == cyc) begin
              case (evq[i].k)
                E_GOOD:  begin good = 1'b1; gd = evq[i].d; end
                E_PERR:  xp = 1'b1;
                default: xf = 1'b1;
              endcase
              evq.delete(i);
            end
          end
          hv = m_v[l];
          if (hv && r_rdy[l]) m_v[l] = 1'b0;
          if (good) begin
            if (!hv || r_rdy[l]) begin
              m_v[l] = 1'b1;
              m_d[l] = gd;
            end else begin
              xo = 1'b1;
            end
          end
        end
        check("m_valid", l, 32'(mv[l]), 32'(m_v[l]));
        check("m_data", l, 32'(md[l]), 32'(m_d[l]));
        check("parity_err", l, 32'(pe[l]), 32'(xp));
        check("frame_err", l, 32'(fe[l]), 32'(xf));
        check("overrun", l, 32'(ov[l]), 32'(xo));
        if (mv[l] === 1'b1 && prev_mv[l] !== 1'b1) rise_at[l] = cyc;
        if (pe[l] === 1'b1 || fe[l] === 1'b1 || ov[l] === 1'b1)
          pulse_at[l] = cyc;
      end
      prev_mv = mv;
    end
  end

  initial begin : stim
    int c0, h0, p0, r0, gc;
    rx  = 2'b11;
    rdy = 2'b11;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("rst_m_data", 0, 32'(md[0]), 32'h00);
    check("rst_m_valid", 0, 32'(mv[0]), 32'h0);

    c0 = cyc;
    send(0, 8'hA5, -1, -1, -1);
    idle(BIT);
    check("a5_latency", 0, rise_at[0] - c0, 311);
    check("a5_data", 0, 32'(md[0]), 32'hA5);
    check("a5_handshakes", 0, hs_cnt[0], 1);

    c0 = cyc;
    send(1, 8'h03, 1, -1, -1);
    idle(BIT);
    check("perr_latency", 1, pulse_at[1] - c0, 343);
    check("perr_no_valid", 1, rise_at[1], 0);
    c0 = cyc;
    send(1, 8'h03, 0, -1, -1);
    idle(BIT);
    check("par_ok_latency", 1, rise_at[1] - c0, 343);
    check("par_ok_data", 1, 32'(md[1]), 32'h03);

    rdy[0] = 1'b0;
    send(0, 8'h11, -1, -1, -1);
    c0 = cyc;
    send(0, 8'h22, -1, -1, -1);
    idle(BIT);
    check("ovr_latency", 0, pulse_at[0] - c0, 311);
    check("ovr_held", 0, 32'(md[0]), 32'h11);
    check("ovr_valid", 0, 32'(mv[0]), 32'h1);
    h0 = hs_cnt[0];
    rdy[0] = 1'b1;
    idle(4);
    check("ovr_one_take", 0, hs_cnt[0] - h0, 1);
    check("ovr_dropped", 0, 32'(mv[0]), 32'h0);

    c0 = cyc;
    r0 = rise_at[0];
    send_break(0, 20);
    check("brk_latency", 0, pulse_at[0] - c0, 311);
    check("brk_no_valid", 0, rise_at[0], r0);
    idle(2 * BIT);
    send(0, 8'h5A, -1, -1, -1);
    idle(BIT);
    check("brk_next", 0, 32'(md[0]), 32'h5A);

    p0 = pulse_at[0];
    r0 = rise_at[0];
    rx[0] = 1'b0;
    idle(DIV);
    rx[0] = 1'b1;
    idle(2 * BIT);
    check("glitch_no_valid", 0, rise_at[0], r0);
    check("glitch_no_pulse", 0, pulse_at[0], p0);

`ifdef UART_RX_MAJORITY_EN
    gc = 3 * BIT + 2 * (OS / 2 + 1) + 2;
`else
    gc = 3 * BIT + 2 * (OS / 2) + 2;
`endif
    send(0, 8'h3C, -1, gc, -1);
    idle(BIT);
    check("vote_data", 0, 32'(md[0]), 32'h3C);

    send(0, 8'hFF, -1, -1, 5 * BIT + 10);
    check("abort_m_data", 0, 32'(md[0]), 32'h00);
    check("abort_m_valid", 0, 32'(mv[0]), 32'h0);
    idle(10);
    c0 = cyc;
    send(0, 8'h81, -1, -1, -1);
    idle(BIT);
    check("after_rst_latency", 0, rise_at[0] - c0, 311);
    check("after_rst_data", 0, 32'(md[0]), 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
